// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM encoding
// and small access-decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } state_t;

   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   access_size = 3'd1;
         2'b01:   access_size = 3'd2;
         default: access_size = 3'd4;
      endcase
   endfunction

   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      if (we) begin
         case (funct3)
            F3_SB, F3_SH, F3_SW: funct3_legal = 1'b1;
            default:             funct3_legal = 1'b0;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_legal = 1'b1;
            default:                             funct3_legal = 1'b0;
         endcase
      end
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, plus
// load byte/halfword extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [31:0] lane_wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   // Store lanes: replicate the right-aligned data and strobe the addressed bytes.
   always_comb begin
      lane_wdata = wdata;
      wstrb      = 4'b0000;
      case (funct3[1:0])
         2'b00: begin
            lane_wdata = {4{wdata[7:0]}};
            wstrb      = 4'b0001 << offset;
         end
         2'b01: begin
            lane_wdata = {2{wdata[15:0]}};
            wstrb      = 4'b0011 << offset;
         end
         2'b10:   wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

   // Load extension from the lane selected by the byte offset.
   always_comb begin
      case (funct3)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   load_data = rdata;
         F3_LBU:  load_data = {24'd0, shifted[7:0]};
         F3_LHU:  load_data = {16'd0, shifted[15:0]};
         default: load_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the MEM stage and a word-wide data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault
// instead of being silently aligned down.
module lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_SIZE = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        err
);

   state_t      state_r;
   logic        we_r;
   logic [2:0]  funct3_r;
   logic [1:0]  offset_r;
   logic [4:0]  rd_r;

   logic [31:0] eff_addr_s;
   logic        misalign_s;
   logic [32:0] end_addr_s;
   logic        fault_s;
   logic [2:0]  al_funct3_s;
   logic [1:0]  al_offset_s;
   logic [31:0] lane_wdata_s;
   logic [3:0]  wstrb_s;
   logic [31:0] load_data_s;

   assign req_ready = (state_r == IDLE);
   assign busy      = ~reset & ((state_r != IDLE) | (req_valid & req_ready));

   // Effective address and misalignment handling for the incoming request.
   always_comb begin
      eff_addr_s = req_addr;
      misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_funct3[1:0])
         2'b01:   misalign_s = req_addr[0];
         2'b10:   misalign_s = |req_addr[1:0];
         default: misalign_s = 1'b0;
      endcase
`else
      case (req_funct3[1:0])
         2'b01:   eff_addr_s[0]   = 1'b0;
         2'b10:   eff_addr_s[1:0] = 2'b00;
         default: eff_addr_s      = req_addr;
      endcase
`endif
   end

   // Bounds use the raw address so an overhanging access faults even when aligned down.
   assign end_addr_s = {1'b0, req_addr} + {30'd0, access_size(req_funct3)};
   assign fault_s    = ~funct3_legal(req_we, req_funct3) | misalign_s
                     | (end_addr_s > 33'(DMEM_SIZE));

   assign al_funct3_s = (state_r == IDLE) ? req_funct3 : funct3_r;
   assign al_offset_s = (state_r == IDLE) ? eff_addr_s[1:0] : offset_r;

   lsu_align u_align (
      .funct3     (al_funct3_s),
      .offset     (al_offset_s),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .lane_wdata (lane_wdata_s),
      .wstrb      (wstrb_s),
      .load_data  (load_data_s)
   );

   // Access FSM with registered bus, response and fault outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         we_r      <= 1'b0;
         funct3_r  <= 3'd0;
         offset_r  <= 2'd0;
         rd_r      <= 5'd0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         mem_wstrb <= 4'b0000;
         rsp_valid <= 1'b0;
         rsp_rd    <= 5'd0;
         rsp_data  <= 32'd0;
         err       <= 1'b0;
      end else begin
         err       <= 1'b0;
         rsp_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  if (fault_s) begin
                     err <= 1'b1;
                  end else begin
                     we_r      <= req_we;
                     funct3_r  <= req_funct3;
                     offset_r  <= eff_addr_s[1:0];
                     rd_r      <= req_rd;
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {eff_addr_s[31:2], 2'b00};
                     mem_wdata <= lane_wdata_s;
                     mem_wstrb <= req_we ? wstrb_s : 4'b0000;
                     state_r   <= BUS;
                  end
               end
            end
            BUS: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state_r   <= we_r ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  rsp_data  <= load_data_s;
                  rsp_rd    <= rd_r;
                  rsp_valid <= 1'b1;
                  state_r   <= RESP;
               end
            end
            RESP:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a driver issues accesses and queues the expected
// bus requests, responses and faults; a monitor checks them as they appear.
module tb_lsu;

   localparam int DMEM = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [4:0]  req_rd = 5'd0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        rsp_valid;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        busy;
   logic        err;

   lsu #(.DMEM_SIZE(DMEM)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
      .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          at;
   } rsp_exp_t;

   mem_exp_t mq[$];
   rsp_exp_t rq[$];
   int       eq[$];
   int       total = 0;
   int       bad = 0;
   int       busy_total = 0;
   int       mv_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: DUT asserted it with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Reference model: plain arithmetic on byte sizes and offsets.
   function automatic int size_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit is_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 <= 3'd2;
      return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input longint off,
                                              input logic [31:0] rdata);
      longint sz;
      longint v;
      sz = size_of(f3);
      v  = rdata;
      v  = v >> (8 * off);
      if (sz < 4) begin
         v = v % (64'sd1 <<< (8 * sz));
         if (f3[2] == 1'b0 && v >= (64'sd1 <<< (8 * sz - 1))) v = v - (64'sd1 <<< (8 * sz));
      end
      return v[31:0];
   endfunction

   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int rdly, input int vdly, input logic [31:0] rdata);
      bit       fault;
      longint   sz;
      longint   eff;
      longint   off;
      mem_exp_t me;
      rsp_exp_t re;
      sz    = size_of(f3);
      fault = !is_legal(we, f3) || (longint'(addr) + sz > DMEM);
`ifdef LSU_MISALIGN_TRAP_EN
      if (longint'(addr) % sz != 0) fault = 1'b1;
      eff = addr;
`else
      eff = longint'(addr) - longint'(addr) % sz;
`endif
      off = eff % 4;
      if (!fault) begin
         me.addr  = 32'(eff - off);
         me.we    = we;
         me.strb  = 4'b0000;
         me.wdata = 32'd0;
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (i >= off && i < off + sz) me.strb[i] = 1'b1;
               me.wdata[8*i +: 8] = 8'(wdata >> (8 * (i % sz)));
            end
         end else begin
            me.wdata = 32'hx;
         end
         mq.push_back(me);
      end
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      @(posedge clock); #1;
      req_valid = 1'b0;
      if (fault) begin
         eq.push_back(cyc);
         @(posedge clock); #1;
         return;
      end
      repeat (rdly) begin @(posedge clock); #1; end
      mem_ready = 1'b1;
      if (!we) begin
         mem_rvalid = 1'b1;
         mem_rdata  = ~rdata;
      end
      @(posedge clock); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (we) return;
      repeat (vdly) begin @(posedge clock); #1; end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      re.rd   = rd;
      re.data = model_load(f3, off, rdata);
      re.at   = cyc;
      rq.push_back(re);
      @(posedge clock); #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int b0;
      int m0;
      fork
         forever begin
            @(negedge clock);
            if (busy) busy_total++;
            if (mem_valid) mv_total++;
            if (mem_valid) begin
               if (mq.size() == 0) begin
                  unexpected("mem_valid");
               end else begin
                  chk("mem_addr", mem_addr, mq[0].addr);
                  chk("mem_we", {31'd0, mem_we}, {31'd0, mq[0].we});
                  chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, mq[0].strb});
                  if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].wdata);
                  if (mem_ready) void'(mq.pop_front());
               end
            end
            if (rsp_valid) begin
               if (rq.size() == 0) begin
                  unexpected("rsp_valid");
               end else begin
                  chk("rsp_data", rsp_data, rq[0].data);
                  chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, rq[0].rd});
                  chk("rsp_cycle", 32'(cyc), 32'(rq[0].at));
                  void'(rq.pop_front());
               end
            end
            if (err) begin
               if (eq.size() == 0) begin
                  unexpected("err");
               end else begin
                  chk("err_cycle", 32'(cyc), 32'(eq[0]));
                  void'(eq.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check_reset_outputs();

      b0 = busy_total;
      access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0);
      chk("sw_busy_cycles", 32'(busy_total - b0), 32'd2);

      access(1'b0, 3'b000, 32'h13, 32'd0, 5'd7, 0, 0, 32'h80FF7F01);
      chk("lb_rsp_data", rsp_data, 32'hFFFFFF80);
      chk("lb_rsp_rd", {27'd0, rsp_rd}, 32'd7);

      m0 = mv_total;
      access(1'b0, 3'b101, 32'h12, 32'd0, 5'd9, 3, 1, 32'h80FF7F01);
      chk("lhu_mem_valid_cycles", 32'(mv_total - m0), 32'd4);
      chk("lhu_rsp_data", rsp_data, 32'h000080FF);

      access(1'b1, 3'b001, 32'h21, 32'h0000A5C3, 5'd0, 1, 0, 32'd0);
      access(1'b0, 3'b010, 32'hFFE, 32'd0, 5'd3, 0, 0, 32'h12345678);

      // Reset while waiting for read data; the late rvalid must be dropped.
      mq.push_back('{addr: 32'h40, we: 1'b0, strb: 4'b0000, wdata: 32'hx});
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_rd = 5'd5;
      @(posedge clock); #1;
      req_valid = 1'b0;
      mem_ready = 1'b1;
      @(posedge clock); #1;
      mem_ready = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check_reset_outputs();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (2) @(posedge clock);
      #1;

      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0:       a = DMEM - 8 + $urandom_range(0, 15);
            1:       a = $urandom;
            default: a = $urandom_range(0, DMEM - 1);
         endcase
         access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      repeat (4) @(posedge clock);
      #1;
      chk("mem_queue_drained", 32'(mq.size()), 32'd0);
      chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
      chk("err_queue_drained", 32'(eq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
